// File: rtl/pitch_shift_pkg.sv
// Shared types and helpers for the dual-tap crossfading pitch shifter.
package pitch_shift_pkg;

  typedef enum logic [2:0] {IDLE, WR, RDA, RDB, MAC, OUT} ps_state_t;

  // Full-wet mix CV for the default 16-bit sample width.
  localparam int MIX_MAX = 32767;

  // Clamp a wide signed value into the signed range of a w-bit sample.
  function automatic logic signed [63:0] sat_w(input logic signed [63:0] x, input int w);
    logic signed [63:0] hi, lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

endpackage

// File: rtl/delay_ram.sv
// Simple dual-port delay line storage, synchronous read with one cycle of latency.
module delay_ram #(
  parameter int W     = 16,
  parameter int DEPTH = 2048
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [W-1:0]             wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [W-1:0]             rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/pitch_shift_xfade.sv
// Dual-tap crossfading pitch shifter: two taps half a buffer apart with
// complementary triangular gains, dry/wet mix and a window-phase CV output.
module pitch_shift_xfade
  import pitch_shift_pkg::*;
#(
  parameter int W     = 16,
  parameter int DEPTH = 2048,
  parameter int FRAC  = 8,
  parameter int SHIFT = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sample_clk,
  input  logic signed [W-1:0] sample_in0,
  input  logic signed [W-1:0] sample_in1,
  input  logic signed [W-1:0] sample_in2,
  input  logic signed [W-1:0] sample_in3,
  output logic signed [W-1:0] sample_out0,
  output logic signed [W-1:0] sample_out1,
  output logic signed [W-1:0] sample_out2,
  output logic signed [W-1:0] sample_out3
);

  localparam int A  = $clog2(DEPTH);
  localparam int P  = A + FRAC;
  localparam int MW = W + A + 1;
  localparam int XW = 2 * W + 2;
  localparam logic [A-1:0] HALF     = A'(DEPTH / 2);
  localparam logic [W:0]   OUT3_MAX = {2'b00, {(W-1){1'b1}}};

  ps_state_t            state;
  logic                 sclk_q, strobe, filled;
  logic [A-1:0]         wr_ptr, da, db, ga, gb, raddr;
  logic [P-1:0]         ph;
  logic signed [W-1:0]  dry_q, pitch_q, mix_q, a_q, b_q, wet_q, step_w;
  logic [W-1:0]         rdata;
  logic signed [MW-1:0] acc;
  logic signed [W:0]    m_s, mi_s;
  logic signed [XW-1:0] mix_acc;
  logic [W:0]           g_sh;
  logic                 unused_in3;

  assign unused_in3 = ^sample_in3;
  assign strobe     = sample_clk & ~sclk_q;

  // Tap A delay is the integer part of the phase; tap B sits half a buffer away.
  assign da    = ph[P-1:FRAC];
  assign db    = da + HALF;
  assign ga    = (da <= HALF) ? da : '0 - da;
  assign gb    = HALF - ga;
  assign raddr = (state == WR) ? wr_ptr - da : wr_ptr - db;

  // gA + gB == DEPTH/2, so the shift turns the weighted sum into an average.
  assign acc = MW'(a_q) * MW'($signed({1'b0, ga})) + MW'(b_q) * MW'($signed({1'b0, gb}));

  assign m_s     = mix_q[W-1] ? '0 : {1'b0, mix_q};
  assign mi_s    = $signed(OUT3_MAX) - m_s;
  assign mix_acc = XW'(dry_q) * XW'(mi_s) + XW'(wet_q) * XW'(m_s);

  assign step_w = pitch_q >>> SHIFT;
  assign g_sh   = (W+1)'(ga) << (W - A);

  delay_ram #(.W(W), .DEPTH(DEPTH)) u_ram (
    .clk   (clk),
    .we    (state == WR),
    .waddr (wr_ptr),
    .wdata (sample_in0),
    .raddr (raddr),
    .rdata (rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      sclk_q      <= 1'b0;
      filled      <= 1'b0;
      wr_ptr      <= '0;
      ph          <= '0;
      dry_q       <= '0;
      pitch_q     <= '0;
      mix_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      wet_q       <= '0;
      sample_out0 <= '0;
      sample_out1 <= '0;
      sample_out2 <= '0;
      sample_out3 <= '0;
    end else begin
      sclk_q <= sample_clk;
      unique case (state)
        IDLE: if (strobe) state <= WR;
        WR: begin
          dry_q   <= sample_in0;
          pitch_q <= sample_in1;
          mix_q   <= sample_in2;
          state   <= RDA;
        end
        RDA: begin
          // A zero delay means the sample written this very cycle.
          a_q   <= (da == '0) ? dry_q : $signed(rdata);
          state <= RDB;
        end
        RDB: begin
          b_q   <= $signed(rdata);
          state <= MAC;
        end
        MAC: begin
          wet_q <= filled ? W'(sat_w(64'(acc >>> (A - 1)), W)) : '0;
          state <= OUT;
        end
        OUT: begin
          sample_out0 <= dry_q;
          sample_out1 <= wet_q;
          sample_out2 <= W'(sat_w(64'(mix_acc >>> (W - 1)), W));
          sample_out3 <= (g_sh > OUT3_MAX) ? OUT3_MAX[W-1:0] : g_sh[W-1:0];
          wr_ptr      <= wr_ptr + A'(1);
          if (wr_ptr == A'(DEPTH - 1)) filled <= 1'b1;
          ph          <= ph + P'(step_w);
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pitch_shift_xfade.sv
// Randomized scoreboard bench for pitch_shift_xfade with a small-buffer configuration.
module tb_pitch_shift_xfade;
  import pitch_shift_pkg::*;

  localparam int W     = 16;
  localparam int DEPTH = 16;
  localparam int FRAC  = 8;
  localparam int SHIFT = 6;
  localparam int HALF  = DEPTH / 2;
  localparam int PMOD  = DEPTH * (1 << FRAC);
  localparam int GSCL  = 1 << (W - $clog2(DEPTH));

  logic clk = 1'b0, rst = 1'b1, sample_clk = 1'b0;
  logic signed [W-1:0] sample_in0 = '0, sample_in1 = '0, sample_in2 = '0, sample_in3 = '0;
  logic signed [W-1:0] sample_out0, sample_out1, sample_out2, sample_out3;

  pitch_shift_xfade #(.W(W), .DEPTH(DEPTH), .FRAC(FRAC), .SHIFT(SHIFT)) dut (
    .clk(clk), .rst(rst), .sample_clk(sample_clk),
    .sample_in0(sample_in0), .sample_in1(sample_in1),
    .sample_in2(sample_in2), .sample_in3(sample_in3),
    .sample_out0(sample_out0), .sample_out1(sample_out1),
    .sample_out2(sample_out2), .sample_out3(sample_out3)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int due;
    int o0, o1, o2, o3;
  } exp_t;

  exp_t pend[$];
  exp_t cur = '{0, 0, 0, 0, 0};
  int   nchk = 0, npass = 0;
  int   int_req = 0, int_done = 0;

  // Reference model state
  int mram[DEPTH];
  int mwp = 0, mph = 0;
  bit mfilled = 1'b0;

  function automatic longint fdiv(longint n, longint d);
    longint q;
    q = n / d;
    if ((n % d != 0) && ((n < 0) != (d < 0))) q = q - 1;
    return q;
  endfunction

  function automatic int sat16(longint x);
    if (x > 32767) return 32767;
    if (x < -32768) return -32768;
    return int'(x);
  endfunction

  function automatic int rnd16();
    logic signed [15:0] t;
    t = 16'($urandom());
    return int'(t);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One accepted sample: expected outputs appear 6 edges after the strobe is driven.
  task automatic model_push(input int d0, input int d1, input int d2);
    exp_t e;
    int dA, dB, gA, gB, a, b, wet, m;
    mram[mwp] = d0;
    dA  = mph / (1 << FRAC);
    dB  = (dA + HALF) % DEPTH;
    gA  = (dA <= HALF) ? dA : DEPTH - dA;
    gB  = HALF - gA;
    a   = mram[((mwp - dA) % DEPTH + DEPTH) % DEPTH];
    b   = mram[((mwp - dB) % DEPTH + DEPTH) % DEPTH];
    wet = mfilled ? sat16(fdiv(longint'(a) * gA + longint'(b) * gB, HALF)) : 0;
    m   = (d2 < 0) ? 0 : d2;
    e.due = cyc + 6;
    e.o0  = d0;
    e.o1  = wet;
    e.o2  = sat16(fdiv(longint'(d0) * (MIX_MAX - m) + longint'(wet) * m, 32768));
    e.o3  = (gA * GSCL > MIX_MAX) ? MIX_MAX : gA * GSCL;
    pend.push_back(e);
    if (mwp == DEPTH - 1) mfilled = 1'b1;
    mwp = (mwp + 1) % DEPTH;
    mph = ((mph + int'(fdiv(d1, 64))) % PMOD + PMOD) % PMOD;
  endtask

  task automatic issue(input int d0, input int d1, input int d2, input int per, input bit redge);
    sample_clk = 1'b1;
    sample_in0 = 16'(d0);
    sample_in1 = 16'(d1);
    sample_in2 = 16'(d2);
    sample_in3 = 16'($urandom());
    model_push(d0, d1, d2);
    tick();
    if (redge) begin
      // Second rising edge lands while the pipeline is busy and must be lost.
      sample_clk = 1'b0;
      tick();
      sample_clk = 1'b1;
      tick();
      sample_clk = 1'b0;
      repeat (per - 3) tick();
    end else begin
      tick();
      sample_clk = 1'b0;
      repeat (per - 2) tick();
    end
  endtask

  task automatic mid_reset();
    exp_t z;
    sample_clk = 1'b1;
    sample_in0 = 16'(rnd16());
    sample_in1 = 16'(rnd16());
    sample_in2 = 16'(rnd16());
    repeat (3) tick();
    rst = 1'b1;
    while (pend.size() > 0 && pend[pend.size()-1].due > cyc) void'(pend.pop_back());
    z = '{cyc + 1, 0, 0, 0, 0};
    pend.push_back(z);
    mwp = 0;
    mph = 0;
    mfilled = 1'b0;
    tick();
    sample_clk = 1'b0;
    tick();
    int_req++;
    rst = 1'b0;
    repeat (3) tick();
  endtask

  always @(negedge clk) begin
    if (pend.size() > 0 && pend[0].due < cyc) begin
      nchk++;
      $display("FAIL expect_timeout due=%0d now=%0d", pend[0].due, cyc);
      void'(pend.pop_front());
    end
    if (pend.size() > 0 && pend[0].due == cyc) cur = pend.pop_front();
    if (cyc >= 1) begin
      nchk++;
      if (int'(sample_out0) == cur.o0 && int'(sample_out1) == cur.o1 &&
          int'(sample_out2) == cur.o2 && int'(sample_out3) == cur.o3)
        npass++;
      else
        $display("FAIL outputs cyc=%0d got %0d %0d %0d %0d expected %0d %0d %0d %0d", cyc,
                 sample_out0, sample_out1, sample_out2, sample_out3, cur.o0, cur.o1, cur.o2, cur.o3);
    end
    if (int_req != int_done) begin
      int_done = int_req;
      nchk++;
      if (dut.state == IDLE && dut.wr_ptr == '0 && dut.ph == '0 && !dut.filled)
        npass++;
      else
        $display("FAIL reset_state got state=%0d wr_ptr=%0d ph=%0d filled=%0d expected 0 0 0 0",
                 dut.state, dut.wr_ptr, dut.ph, dut.filled);
    end
  end

  initial begin
    int mixes[6];
    mixes = '{0, MIX_MAX, -5, 100, 16384, 30000};
    // Reset with inputs nonzero and sample_clk already high: one strobe after release.
    rst        = 1'b1;
    sample_clk = 1'b1;
    sample_in0 = 16'sd1000;
    sample_in1 = '0;
    sample_in2 = 16'(MIX_MAX);
    sample_in3 = 16'h1234;
    repeat (3) tick();
    int_req++;
    rst = 1'b0;
    model_push(1000, 0, MIX_MAX);
    tick();
    sample_clk = 1'b0;
    repeat (6) tick();

    // Ramp with no pitch shift, fully wet: fills the buffer, then fixed half-buffer delay.
    for (int k = 0; k < 40; k++) issue(k, 0, MIX_MAX, $urandom_range(7, 10), 1'b0);

    // Mix sweep on a constant input.
    for (int k = 0; k < 18; k++) issue(16384, 0, mixes[k % 6], 7, 1'b0);

    // Large negative pitch: phase wraps downward, window gain is a triangle.
    for (int k = 0; k < 24; k++)
      issue(rnd16(), -32768, int'($urandom_range(0, MIX_MAX)), $urandom_range(7, 9), 1'b0);

    // Fully random, with periodic busy re-edges that must be dropped.
    for (int k = 0; k < 40; k++)
      issue(rnd16(), rnd16(), rnd16(), $urandom_range(7, 10), (k % 10) == 3);

    mid_reset();

    for (int k = 0; k < 30; k++)
      issue(rnd16(), rnd16(), rnd16(), $urandom_range(7, 10), (k % 7) == 5);

    repeat (8) tick();
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
